// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry output FIFO carrying {ImmExt, tag, illegal}.
// Optional macro IMM_ZIMM_EN: ImmSrc 101 yields the zero-extended CSR immediate.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and in_ready depends only on the
  // stored occupancy, so there is no combinational path from out_ready.
  logic            push;
  logic            pop;
  logic [31:0]     imm32;
  logic            illegal_c;
  logic [XLEN-1:0] imm_ext;

  logic [XLEN-1:0]  imm_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic             ill_q [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  always_comb begin
    imm32     = '0;
    illegal_c = 1'b0;
    case (ImmSrc)
      3'b000: imm32 = {{20{Instr[31]}}, Instr[31:20]};
      3'b001: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      3'b010: imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                       Instr[11:8], 1'b0};
      3'b011: imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                       Instr[30:21], 1'b0};
      3'b100: imm32 = {Instr[31:12], 12'b0};
`ifdef IMM_ZIMM_EN
      3'b101: imm32 = {27'b0, Instr[19:15]};
`endif
      default: begin
        imm32     = '0;
        illegal_c = 1'b1;
      end
    endcase
  end

  // Bit 31 of imm32 already holds the sign (zero for zimm), so widening to
  // XLEN only replicates it further.
  assign imm_ext = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
        ill_q[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        imm_q[wr_ptr] <= imm_ext;
        tag_q[wr_ptr] <= in_tag;
        ill_q[wr_ptr] <= illegal_c;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset, so the head slot reads as zero while empty after reset.
  assign ImmExt      = imm_q[rd_ptr];
  assign out_tag     = tag_q[rd_ptr];
  assign out_illegal = ill_q[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed testbench for imm_gen_pipe; a second XLEN=64 instance shares the stimulus.
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr_w;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      ImmExt;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  logic             in_ready64;
  logic             out_valid64;
  logic [63:0]      ImmExt64;
  logic [TAG_W-1:0] out_tag64;
  logic             out_illegal64;

  int checks;
  int errors;
  logic [TAG_W-1:0] exp_q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(instr_w[31:7]), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .ImmExt(ImmExt),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .Instr(instr_w[31:7]), .ImmSrc(ImmSrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .ImmExt(ImmExt64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [TAG_W-1:0] tag);
    in_valid = v;
    instr_w  = ins;
    ImmSrc   = src;
    in_tag   = tag;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (ImmExt !== 32'h0 || out_tag !== '0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: imm=%h tag=%0d ill=%b want 0 0 0", ImmExt, out_tag, out_illegal);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_formats;
    logic [31:0] v_ins [8];
    logic [2:0]  v_src [8];
    logic [31:0] v_exp [8];
    logic        v_ill [8];
    v_ins[0] = 32'hFE000CE3; v_src[0] = 3'b010; v_exp[0] = 32'hFFFFFFF8; v_ill[0] = 1'b0;
    v_ins[1] = 32'h0010006F; v_src[1] = 3'b011; v_exp[1] = 32'h00000800; v_ill[1] = 1'b0;
    v_ins[2] = 32'h123450B7; v_src[2] = 3'b100; v_exp[2] = 32'h12345000; v_ill[2] = 1'b0;
    v_ins[3] = 32'hFFF00093; v_src[3] = 3'b000; v_exp[3] = 32'hFFFFFFFF; v_ill[3] = 1'b0;
    v_ins[4] = 32'h7FF00093; v_src[4] = 3'b000; v_exp[4] = 32'h000007FF; v_ill[4] = 1'b0;
    v_ins[5] = 32'hFE000E23; v_src[5] = 3'b001; v_exp[5] = 32'hFFFFFFFC; v_ill[5] = 1'b0;
    v_ins[6] = 32'hFFFFFFFF; v_src[6] = 3'b111; v_exp[6] = 32'h00000000; v_ill[6] = 1'b1;
    v_ins[7] = 32'h000F8073; v_src[7] = 3'b101;
`ifdef IMM_ZIMM_EN
    v_exp[7] = 32'h0000001F; v_ill[7] = 1'b0;
`else
    v_exp[7] = 32'h00000000; v_ill[7] = 1'b1;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v_ins[i], v_src[i], TAG_W'(i + 8));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || ImmExt !== v_exp[i] || out_illegal !== v_ill[i] ||
          out_tag !== TAG_W'(i + 8)) begin
        errors++;
        $display("FAIL fmt_%0d: v=%b imm=%h ill=%b tag=%0d want 1 %h %b %0d", i,
                 out_valid, ImmExt, out_illegal, out_tag, v_exp[i], v_ill[i], i + 8);
      end
    end
    drive(1'b0, 32'h0, 3'b000, '0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fmt_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_xlen64;
    out_ready = 1'b1;
    drive(1'b1, 32'h800000B7, 3'b100, 5'd5);
    @(negedge clk);
    drive(1'b0, 32'h0, 3'b000, '0);
    checks++;
    if (out_valid64 !== 1'b1 || ImmExt64 !== 64'hFFFFFFFF80000000 || ImmExt !== 32'h80000000) begin
      errors++;
      $display("FAIL x64_u: v=%b imm64=%h imm32=%h want 1 ffffffff80000000 80000000",
               out_valid64, ImmExt64, ImmExt);
    end
    drive(1'b1, 32'hFE000CE3, 3'b010, 5'd6);
    @(negedge clk);
    drive(1'b0, 32'h0, 3'b000, '0);
    checks++;
    if (ImmExt64 !== 64'hFFFFFFFFFFFFFFF8 || out_tag64 !== 5'd6 || out_illegal64 !== 1'b0) begin
      errors++;
      $display("FAIL x64_b: imm64=%h tag=%0d ill=%b want fffffffffffffff8 6 0",
               ImmExt64, out_tag64, out_illegal64);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int pops;
    bit drop;
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'b000, 5'd1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_one: in_ready=%b out_valid=%b want 1 1", in_ready, out_valid);
    end
    drive(1'b1, 32'h00200093, 3'b000, 5'd2);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b want 0", in_ready);
    end
    drive(1'b1, 32'h00300093, 3'b000, 5'd3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 5'd1 || ImmExt !== 32'h1) begin
      errors++;
      $display("FAIL bp_hold: in_ready=%b tag=%0d imm=%h want 0 1 1", in_ready, out_tag, ImmExt);
    end
    exp_q = {5'd1, 5'd2, 5'd3};
    out_ready = 1'b1;
    pops = 0;
    drop = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (drop) in_valid = 1'b0;
      if (out_valid && out_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: popped tag=%0d with nothing expected", out_tag);
        end else if (out_tag !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_order: tag=%0d want %0d", out_tag, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) drop = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (pops != 3 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: pops=%0d left=%0d out_valid=%b want 3 0 0",
               pops, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 3'b000, 5'd10);
    @(negedge clk);
    drive(1'b1, 32'h00B00093, 3'b000, 5'd11);
    @(negedge clk);
    drive(1'b0, 32'h0, 3'b000, '0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ImmExt !== 32'h0 || out_tag !== '0) begin
      errors++;
      $display("FAIL rst_async: v=%b rdy=%b imm=%h tag=%0d want 0 1 0 0",
               out_valid, in_ready, ImmExt, out_tag);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 32'hFFE00093, 3'b000, 5'd7);
    @(negedge clk);
    drive(1'b0, 32'h0, 3'b000, '0);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 5'd7 || ImmExt !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL rst_after: v=%b tag=%0d imm=%h want 1 7 fffffffe", out_valid, out_tag, ImmExt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int pops;
    pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(1'b1, 32'(i) << 20, 3'b000, TAG_W'(i));
      else drive(1'b0, 32'h0, 3'b000, '0);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: in_ready=%b want 1", i, in_ready);
      end
      if (i < 10) begin
        checks++;
        if (out_valid !== 1'b1 || out_tag !== TAG_W'(i) || ImmExt !== 32'(i)) begin
          errors++;
          $display("FAIL b2b_%0d: v=%b tag=%0d imm=%h want 1 %0d %h",
                   i, out_valid, out_tag, ImmExt, i, i);
        end else begin
          pops++;
        end
      end
    end
    checks++;
    if (pops != 10 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_total: pops=%0d out_valid=%b want 10 0", pops, out_valid);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'b000, '0);
    test_reset;
    test_formats;
    test_xlen64;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried with each immediate.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream offers Instr/ImmSrc/in_tag this cycle.
REQ-006 Port in_ready  output  1  block accepts an offer this cycle.
REQ-007 Port Instr  input  [31:7]  instruction bits from instruction memory.
REQ-008 Port ImmSrc  input  3  immediate format select from Control Unit.
REQ-009 Port in_tag  input  TAG_W  sideband passed through unmodified.
REQ-010 Port out_valid  output  1  head entry is presented on the outputs.
REQ-011 Port out_ready  input  1  downstream consumes the head entry this cycle.
REQ-012 Port ImmExt  output  XLEN  extended immediate of the head entry.
REQ-013 Port out_tag  output  TAG_W  tag of the head entry.
REQ-014 Port out_illegal  output  1  head entry was produced from an unsupported ImmSrc code.

Function
REQ-015 Accept (push) SHALL occur when in_valid and in_ready are both high at a clock edge; pop SHALL occur when out_valid and out_ready are both high.
REQ-016 Storage SHALL be a 2-entry FIFO holding {ImmExt, tag, illegal}; immediate is computed at push and stored already extended.
REQ-017 in_ready SHALL be high iff occupancy < 2, registered, with no combinational path from out_ready.
REQ-018 out_valid SHALL be high iff occupancy > 0; outputs SHALL show the oldest entry and stay stable while out_valid and not out_ready.
REQ-019 Latency SHALL be exactly 1 cycle from push to out_valid when empty; throughput 1 entry/cycle with out_ready held high.
REQ-020 Push and pop in the same cycle at occupancy 1 SHALL leave occupancy 1 with the new entry at the head next cycle; at occupancy 2 only pop is possible.
REQ-021 Pop at occupancy 0 and push at occupancy 2 SHALL have no effect; order SHALL be strictly FIFO; read/write pointers wrap modulo 2.
REQ-022 ImmSrc 000 I-type: sext(Instr[31:20]).
REQ-023 ImmSrc 001 S-type: sext({Instr[31:25], Instr[11:7]}).
REQ-024 ImmSrc 010 B-type: sext({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}).
REQ-025 ImmSrc 011 J-type: sext({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}).
REQ-026 ImmSrc 100 U-type: sext({Instr[31:12], 12'b0}).
REQ-027 Sign extension SHALL replicate Instr[31] up to XLEN bits for all formats above.
REQ-028 Unsupported codes SHALL store ImmExt = 0 and illegal = 1; supported codes store illegal = 0.

Reset
REQ-029 While reset is high, occupancy and both pointers SHALL be 0, in_ready = 1, out_valid = 0, ImmExt = 0, out_tag = 0, out_illegal = 0, independent of clk.
REQ-030 Reset asserted mid-transfer SHALL discard all stored entries; the first push after deassertion SHALL appear after 1 cycle as if from empty.

Configuration
REQ-031 Macro IMM_ZIMM_EN: when defined, ImmSrc 101 SHALL produce zero-extended CSR immediate {0, Instr[19:15]} with illegal = 0; when undefined, 101 SHALL be treated as unsupported per REQ-028.

Verification
REQ-032 XLEN=32, ImmSrc=010, Instr=0xFE000CE3, out_ready=1 -> next cycle out_valid=1, ImmExt=0xFFFFFFF8, out_illegal=0.
REQ-033 ImmSrc=011, Instr=0x0010006F -> ImmExt=0x00000800; ImmSrc=100, Instr=0x123450B7 -> 0x12345000; XLEN=64, ImmSrc=100, Instr=0x800000B7 -> 0xFFFFFFFF80000000.
REQ-034 out_ready=0, push tags 1,2,3 on consecutive cycles -> in_ready low after second push, tag 3 held off; release out_ready -> tags emerge 1,2,3 with no loss or duplication.
REQ-035 ImmSrc=111 -> ImmExt=0, out_illegal=1; ImmSrc=101, Instr[19:15]=0x1F -> 0x1F, illegal=0 with IMM_ZIMM_EN, ImmExt=0, illegal=1 without.
REQ-036 Two entries queued, reset pulsed asynchronously between edges -> out_valid=0 and in_ready=1 immediately; next push emerges 1 cycle later.
REQ-037 Continuous push with out_ready=1 for 10 cycles -> 10 entries out, one per cycle, occupancy never exceeds 1.
